// File: rtl/cpu_types_pkg.sv
// Shared types for the L1 data cache coherence agent.
//   dcachef_t      : processor/snoop word-address split {tag, idx, blkoff, bytoff}
//   msi_t          : per-frame MSI coherence state
//   dcache_frame_t : one direct-mapped frame (state, tag, two data words)
//   req_state_t    : request-side FSM states
//   blk_base()     : block base address {tag, idx, 3'b000}
package cpu_types_pkg;

   localparam int SETS  = 8;
   localparam int WORDS = 2;

   typedef struct packed {
      logic [25:0] tag;
      logic [2:0]  idx;
      logic        blkoff;
      logic [1:0]  bytoff;
   } dcachef_t;

   typedef enum logic [1:0] {
      MSI_I = 2'd0,
      MSI_S = 2'd1,
      MSI_M = 2'd2
   } msi_t;

   typedef struct packed {
      msi_t                    st;
      logic [25:0]             tag;
      logic [WORDS-1:0][31:0]  data;
   } dcache_frame_t;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WB1   = 3'd1,
      WB2   = 3'd2,
      FILL1 = 3'd3,
      FILL2 = 3'd4
   } req_state_t;

   function automatic logic [31:0] blk_base(input logic [25:0] tag, input logic [2:0] idx);
      return {tag, idx, 3'b000};
   endfunction

endpackage

// File: rtl/dcache_coherence_agent_snoop.sv
// coherence_snoop_unit: snoop side of the cache agent.
// Looks up the snooped address, produces the "I hold M" response and the
// supplied word, and remembers the snoop action while ccwait is high so it
// can be applied to the frame array on the first cycle ccwait drops.
// Ports:
//   CLK, nRST      clock / async active-low reset
//   ccwait         controller is snooping this cache
//   ccinv          snoop is BusRdX
//   ccsnoopaddr    snooped word address
//   frames         current frame array (read only)
//   snp_cctrans    snoop hit on an M frame
//   snp_dstore     frame word selected by ccsnoopaddr[2]
//   apply_en       apply the latched action this cycle
//   apply_inv      latched action is invalidate (else downgrade M->S)
//   apply_idx      frame the action targets
module coherence_snoop_unit
   import cpu_types_pkg::*;
(
   input  logic          CLK,
   input  logic          nRST,
   input  logic          ccwait,
   input  logic          ccinv,
   input  logic [31:0]   ccsnoopaddr,
   input  dcache_frame_t frames [SETS],
   output logic          snp_cctrans,
   output logic [31:0]   snp_dstore,
   output logic          apply_en,
   output logic          apply_inv,
   output logic [2:0]    apply_idx
);

   dcachef_t      sa;
   dcache_frame_t sf;
   dcache_frame_t af;
   logic          snp_hit;
   logic          still_hit;
   logic          pend_q;
   logic          inv_q;
   logic          hit_q;
   logic [2:0]    idx_q;
   logic [25:0]   tag_q;
   logic          unused_bytoff;

   assign sa            = ccsnoopaddr;
   assign unused_bytoff = ^sa.bytoff;
   assign sf            = frames[sa.idx];
   assign snp_hit       = (sf.st != MSI_I) && (sf.tag == sa.tag);
   assign snp_cctrans   = ccwait && snp_hit && (sf.st == MSI_M);
   assign snp_dstore    = sf.data[sa.blkoff];

   // Re-check the captured frame at apply time so a fill that completed
   // during the snoop (and overwrote the frame) is left alone.
   assign af        = frames[idx_q];
   assign still_hit = (af.st != MSI_I) && (af.tag == tag_q);
   assign apply_en  = pend_q && !ccwait && hit_q && still_hit;
   assign apply_inv = inv_q;
   assign apply_idx = idx_q;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         pend_q <= 1'b0;
         inv_q  <= 1'b0;
         hit_q  <= 1'b0;
         idx_q  <= '0;
         tag_q  <= '0;
      end else if (ccwait) begin
         pend_q <= 1'b1;
         inv_q  <= inv_q | ccinv;
         if (snp_hit) begin
            hit_q <= 1'b1;
            idx_q <= sa.idx;
            tag_q <= sa.tag;
         end
      end else if (pend_q) begin
         pend_q <= 1'b0;
         inv_q  <= 1'b0;
         hit_q  <= 1'b0;
      end
   end

endmodule

// File: rtl/dcache_coherence_agent.sv
// dcache_coherence_agent: MSI snooping L1 data cache, direct mapped,
// 8 frames x 2 words. Serves processor loads/stores, issues BusRd/BusRdX
// fills and victim writebacks, answers controller snoops.
// Ports:
//   CLK, nRST                   clock / async active-low reset
//   dmemREN, dmemWEN            processor load / store request
//   dmemaddr, dmemstore         processor address / store data
//   dmemload, dhit              load data / request done this cycle
//   dREN, dWEN, daddr           bus fill / writeback request, block base
//   dstore, dload, dwait        bus write data, fill data, word handshake
//   cctrans, ccwrite            coherence request (BusRdX when ccwrite) or snoop M response
//   ccwait, ccinv, ccsnoopaddr  snoop in progress, snoop is BusRdX, snooped address
//
// state | meaning
// IDLE  | serve hits, launch miss/upgrade
// WB1   | write victim word 0 (aborts to FILL1 if victim leaves M)
// WB2   | write victim word 1
// FILL1 | fetch word 0 (BusRd/BusRdX)
// FILL2 | fetch word 1, then install tag and S/M
module dcache_coherence_agent
   import cpu_types_pkg::*;
(
   input  logic        CLK,
   input  logic        nRST,
   input  logic        dmemREN,
   input  logic        dmemWEN,
   input  logic [31:0] dmemaddr,
   input  logic [31:0] dmemstore,
   output logic [31:0] dmemload,
   output logic        dhit,
   output logic        dREN,
   output logic        dWEN,
   output logic [31:0] daddr,
   output logic [31:0] dstore,
   input  logic [31:0] dload,
   input  logic        dwait,
   output logic        cctrans,
   output logic        ccwrite,
   input  logic        ccwait,
   input  logic        ccinv,
   input  logic [31:0] ccsnoopaddr
);

   dcache_frame_t frames [SETS];
   req_state_t    state;
   logic          miss_rw;
   logic [2:0]    req_idx_q;
   logic [25:0]   vic_tag_q;
   logic [25:0]   fill_tag_q;

   dcachef_t      ra;
   dcache_frame_t rf;
   dcache_frame_t cf;
   logic          req_hit;
   logic          blocked;
   logic          idle_ok;
   logic          rd_hit;
   logic          wr_hit;
   logic          start_miss;
   logic          snp_cctrans;
   logic [31:0]   snp_dstore;
   logic          apply_en;
   logic          apply_inv;
   logic [2:0]    apply_idx;
   logic          unused_bytoff;

   coherence_snoop_unit u_snoop (
      .CLK         (CLK),
      .nRST        (nRST),
      .ccwait      (ccwait),
      .ccinv       (ccinv),
      .ccsnoopaddr (ccsnoopaddr),
      .frames      (frames),
      .snp_cctrans (snp_cctrans),
      .snp_dstore  (snp_dstore),
      .apply_en    (apply_en),
      .apply_inv   (apply_inv),
      .apply_idx   (apply_idx)
   );

   assign ra            = dmemaddr;
   assign unused_bytoff = ^ra.bytoff;
   assign rf            = frames[ra.idx];
   assign cf            = frames[req_idx_q];
   assign req_hit       = (rf.st != MSI_I) && (rf.tag == ra.tag);

   // A pending snoop action on the requested frame lands at this edge; hold
   // the request for a cycle so a store cannot complete on a frame that is
   // being downgraded or invalidated at the same time.
   assign blocked    = apply_en && (apply_idx == ra.idx);
   assign idle_ok    = (state == IDLE) && !ccwait && !blocked;
   assign rd_hit     = idle_ok && dmemREN && req_hit;
   assign wr_hit     = idle_ok && dmemWEN && req_hit && (rf.st == MSI_M);
   assign start_miss = idle_ok && (dmemREN || dmemWEN) && !(rd_hit || wr_hit);

   assign dhit     = rd_hit || wr_hit;
   assign dmemload = rd_hit ? rf.data[ra.blkoff] : 32'd0;

   always_comb begin
      dWEN    = 1'b0;
      dREN    = 1'b0;
      daddr   = 32'd0;
      dstore  = 32'd0;
      cctrans = 1'b0;
      ccwrite = 1'b0;
      case (state)
         WB1: begin
            dWEN   = (cf.st == MSI_M);
            daddr  = blk_base(vic_tag_q, req_idx_q);
            dstore = cf.data[0];
         end
         WB2: begin
            dWEN   = 1'b1;
            daddr  = blk_base(vic_tag_q, req_idx_q);
            dstore = cf.data[1];
         end
         FILL1, FILL2: begin
            dREN    = 1'b1;
            daddr   = blk_base(fill_tag_q, req_idx_q);
            cctrans = 1'b1;
            ccwrite = miss_rw;
         end
         default: ;
      endcase
      if (ccwait) begin
         cctrans = snp_cctrans;
         ccwrite = 1'b0;
         dstore  = snp_dstore;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state      <= IDLE;
         miss_rw    <= 1'b0;
         req_idx_q  <= '0;
         vic_tag_q  <= '0;
         fill_tag_q <= '0;
         for (int i = 0; i < SETS; i++) frames[i] <= '0;
      end else begin
         if (apply_en) begin
            if (apply_inv)
               frames[apply_idx].st <= MSI_I;
            else if (frames[apply_idx].st == MSI_M)
               frames[apply_idx].st <= MSI_S;
         end
         case (state)
            IDLE: begin
               if (wr_hit) begin
                  frames[ra.idx].data[ra.blkoff] <= dmemstore;
               end else if (start_miss) begin
                  req_idx_q  <= ra.idx;
                  fill_tag_q <= ra.tag;
                  vic_tag_q  <= rf.tag;
                  miss_rw    <= dmemWEN;
                  // An upgrade (store on S) is a hit, so only a true miss
                  // with an M victim needs a writeback.
                  state      <= (!req_hit && rf.st == MSI_M) ? WB1 : FILL1;
               end
            end
            WB1: begin
               if (cf.st != MSI_M) state <= FILL1;
               else if (!dwait)    state <= WB2;
            end
            WB2: begin
               if (!dwait) state <= FILL1;
            end
            FILL1: begin
               if (!dwait) begin
                  frames[req_idx_q].data[0] <= dload;
                  state <= FILL2;
               end
            end
            FILL2: begin
               if (!dwait) begin
                  frames[req_idx_q].data[1] <= dload;
                  frames[req_idx_q].tag     <= fill_tag_q;
                  frames[req_idx_q].st      <= miss_rw ? MSI_M : MSI_S;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dcache_coherence_agent.sv
module tb_dcache_coherence_agent;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        dmemREN, dmemWEN;
   logic [31:0] dmemaddr, dmemstore, dmemload;
   logic        dhit, dREN, dWEN;
   logic [31:0] daddr, dstore, dload;
   logic        dwait, cctrans, ccwrite, ccwait, ccinv;
   logic [31:0] ccsnoopaddr;

   int n_chk  = 0;
   int n_fail = 0;

   dcache_coherence_agent dut (
      .CLK(CLK), .nRST(nRST),
      .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
      .dmemstore(dmemstore), .dmemload(dmemload), .dhit(dhit),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .dload(dload), .dwait(dwait), .cctrans(cctrans), .ccwrite(ccwrite),
      .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr)
   );

   always #5 CLK = ~CLK;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // One accepted bus word.
   task automatic beat(input logic [31:0] d);
      dwait = 1'b0;
      dload = d;
      step();
      dwait = 1'b1;
      #1;
   endtask

   initial begin
      nRST = 1'b0; dmemREN = 0; dmemWEN = 0; dmemaddr = 0; dmemstore = 0;
      dload = 0; dwait = 1; ccwait = 0; ccinv = 0; ccsnoopaddr = 0;
      step(); step();
      check_val("rst_ctrl", {dREN, dWEN, dhit, cctrans, ccwrite}, 0);
      check_val("rst_daddr", daddr, 0);
      check_val("rst_dstore", dstore, 0);
      nRST = 1'b1;
      step();

      // 1: cold read 0x40
      dmemREN = 1; dmemaddr = 32'h40; #1;
      check_val("t1_miss_dhit", dhit, 0);
      step(); #1;
      check_val("t1_fill_ctrl", {dREN, cctrans, ccwrite, dWEN}, 4'b1100);
      check_val("t1_daddr", daddr, 32'h40);
      beat(32'hA);
      check_val("t1_fill2_dren", dREN, 1);
      beat(32'hB);
      check_val("t1_hit", dhit, 1);
      check_val("t1_load", dmemload, 32'hA);
      check_val("t1_dren_off", dREN, 0);
      step(); dmemREN = 0;

      // 2: store 0x44 on S frame -> upgrade by refetch
      dmemWEN = 1; dmemaddr = 32'h44; dmemstore = 32'h55; #1;
      check_val("t2_s_no_hit", dhit, 0);
      step(); #1;
      check_val("t2_rdx_ctrl", {dREN, cctrans, ccwrite}, 3'b111);
      check_val("t2_daddr", daddr, 32'h40);
      beat(32'hA); beat(32'hB);
      check_val("t2_wr_hit", dhit, 1);
      step(); dmemWEN = 0; dmemREN = 1; #1;
      check_val("t2_rd_hit", dhit, 1);
      check_val("t2_rd_data", dmemload, 32'h55);
      check_val("t2_no_bus", {dREN, dWEN}, 0);
      step(); dmemREN = 0;

      // 3: load 0x80 evicts M frame
      dmemREN = 1; dmemaddr = 32'h80;
      step(); #1;
      check_val("t3_wb1_ctrl", {dWEN, dREN}, 2'b10);
      check_val("t3_wb1_addr", daddr, 32'h40);
      check_val("t3_wb1_data", dstore, 32'hA);
      beat(32'h0);
      check_val("t3_wb2_data", dstore, 32'h55);
      check_val("t3_wb2_addr", daddr, 32'h40);
      beat(32'h0);
      check_val("t3_fill_ctrl", {dREN, dWEN, ccwrite}, 3'b100);
      check_val("t3_fill_addr", daddr, 32'h80);
      beat(32'hC); beat(32'hD);
      check_val("t3_hit", dhit, 1);
      check_val("t3_load", dmemload, 32'hC);
      step(); dmemREN = 0;
      // bring 0x40 back as M with word1 = 0x55 (S victim, no writeback)
      dmemWEN = 1; dmemaddr = 32'h44; dmemstore = 32'h55;
      step(); #1;
      check_val("t3_s_victim_ctrl", {dREN, dWEN, ccwrite}, 3'b101);
      check_val("t3_s_victim_addr", daddr, 32'h40);
      beat(32'hA); beat(32'hB);
      check_val("t3_wr_hit", dhit, 1);
      step(); dmemWEN = 0;

      // 4: snoop BusRd on M frame
      ccwait = 1; ccinv = 0; ccsnoopaddr = 32'h44;
      dmemREN = 1; dmemaddr = 32'h44; #1;
      check_val("t4_cctrans", cctrans, 1);
      check_val("t4_ccwrite", ccwrite, 0);
      check_val("t4_dstore", dstore, 32'h55);
      check_val("t4_dhit_forced0", dhit, 0);
      step(); ccwait = 0; dmemREN = 0;
      step();
      ccwait = 1; #1;
      check_val("t4_now_s_cctrans", cctrans, 0);
      check_val("t4_now_s_dstore", dstore, 32'h55);
      step(); ccwait = 0;
      step();
      dmemREN = 1; dmemaddr = 32'h44; #1;
      check_val("t4_s_rd_hit", dhit, 1);
      check_val("t4_s_rd_data", dmemload, 32'h55);
      step(); dmemREN = 0;

      // 5: snoop BusRdX on S frame -> I
      ccwait = 1; ccinv = 1; ccsnoopaddr = 32'h40; #1;
      check_val("t5_cctrans", cctrans, 0);
      check_val("t5_dstore", dstore, 32'hA);
      step(); ccwait = 0; ccinv = 0;
      step();
      dmemREN = 1; dmemaddr = 32'h40; #1;
      check_val("t5_inv_miss", dhit, 0);
      step(); #1;
      check_val("t5_refill_ctrl", {dREN, ccwrite}, 2'b10);
      check_val("t5_refill_addr", daddr, 32'h40);
      beat(32'hE); beat(32'hF);
      check_val("t5_refill_load", dmemload, 32'hE);
      step(); dmemREN = 0;
      // snoop miss leaves the frame alone
      ccwait = 1; ccinv = 1; ccsnoopaddr = 32'h1C0; #1;
      check_val("t5_miss_cctrans", cctrans, 0);
      step(); ccwait = 0; ccinv = 0;
      step();
      dmemREN = 1; dmemaddr = 32'h40; #1;
      check_val("t5_miss_keep_hit", dhit, 1);
      check_val("t5_miss_keep_data", dmemload, 32'hE);
      step(); dmemREN = 0;

      // victim abort: snoop invalidates the M victim while in WB1
      dmemWEN = 1; dmemaddr = 32'h40; dmemstore = 32'h77;
      step(); beat(32'hE); beat(32'hF);
      check_val("ab_wr_hit", dhit, 1);
      step(); dmemWEN = 0;
      dmemREN = 1; dmemaddr = 32'h80;
      step(); #1;
      check_val("ab_wb1_dwen", dWEN, 1);
      check_val("ab_wb1_data", dstore, 32'h77);
      ccwait = 1; ccinv = 1; ccsnoopaddr = 32'h40; #1;
      check_val("ab_snp_cctrans", cctrans, 1);
      check_val("ab_snp_dstore", dstore, 32'h77);
      step(); ccwait = 0; ccinv = 0;
      step();
      for (int k = 0; k < 4; k++) begin
         if (dREN) break;
         step();
      end
      check_val("ab_fill_start", dREN, 1);
      check_val("ab_fill_addr", daddr, 32'h80);
      beat(32'h11); beat(32'h22);
      check_val("ab_fill_load", dmemload, 32'h11);
      step(); dmemREN = 0;

      // 6: reset during FILL2
      dmemREN = 1; dmemaddr = 32'h40;
      step(); beat(32'h1);
      check_val("t6_in_fill2", dREN, 1);
      nRST = 0; #1;
      check_val("t6_rst_dren", dREN, 0);
      check_val("t6_rst_cctrans", cctrans, 0);
      step(); nRST = 1;
      dmemaddr = 32'h80; #1;
      check_val("t6_old_frame_gone", dhit, 0);
      dmemaddr = 32'h40; #1;
      check_val("t6_load40_miss", dhit, 0);
      step(); #1;
      check_val("t6_refetch", dREN, 1);
      check_val("t6_refetch_addr", daddr, 32'h40);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
